// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the shared bit-serial adder scheduler.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_core.sv
// Bit-serial LSB-first adder datapath: operand shift registers, carry and
// sum shift register. Sequencing is owned by the enclosing scheduler.
module serial_add_core
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic             s_bit;

    assign s_bit = a_sr[0] ^ b_sr[0] ^ carry;

    // Sum bits enter at the MSB so that after WIDTH shifts the first bit is the LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
        end else if (load) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            carry <= 1'b0;
        end else if (shift_en) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= {s_bit, sum_sr[WIDTH-1:1]};
            carry  <= (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        end
    end

    assign sum = {carry, sum_sr};

endmodule

// File: rtl/serial_add_arbiter.sv
// Round-robin scheduler sharing one bit-serial adder between NREQ requesters,
// returning tagged sums on a single backpressured response channel.
module serial_add_arbiter
    import serial_add_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH:0]        rsp_sum,
    output logic                  busy
);

    localparam int CNTW = $clog2(WIDTH);

    state_t            state;
    state_t            next_state;
    logic [IDW-1:0]    rr_ptr;
    logic [CNTW-1:0]   count;
    logic              grant_found;
    logic [IDW-1:0]    grant_id;
    logic [NREQ-1:0]   grant_onehot;
    logic              load;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        grant_found  = 1'b0;
        grant_id     = '0;
        grant_onehot = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!grant_found && req_valid[(int'(rr_ptr) + i) % NREQ]) begin
                grant_found = 1'b1;
                grant_id    = IDW'((int'(rr_ptr) + i) % NREQ);
            end
        end
        if (grant_found) begin
            grant_onehot[grant_id] = 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_found) next_state = ADD;
            ADD:     if (count == CNTW'(WIDTH - 1)) next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign load      = (state == IDLE) && grant_found;
    assign req_ready = (state == IDLE) ? grant_onehot : '0;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign sel_a     = req_a[int'(grant_id)*WIDTH +: WIDTH];
    assign sel_b     = req_b[int'(grant_id)*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= IDW'(NREQ - 1);
            count  <= '0;
            rsp_id <= '0;
        end else begin
            state <= next_state;
            if (load) begin
                rr_ptr <= grant_id;
                rsp_id <= grant_id;
                count  <= '0;
            end else if (state == ADD) begin
                count <= count + 1'b1;
            end
        end
    end

    serial_add_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (state == ADD),
        .a_in     (sel_a),
        .b_in     (sel_b),
        .sum      (rsp_sum)
    );

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed scoreboard bench for serial_add_arbiter: grant order, latency,
// carry-out, backpressure, reset abort and withdrawn requests.
module tb_serial_add_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;
    localparam int LAT   = WIDTH + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH:0]        rsp_sum;
    logic                  busy;

    typedef struct {
        int             id;
        logic [WIDTH:0] sum;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   last_grant  = 0;
    logic [WIDTH-1:0] op_a [NREQ];
    logic [WIDTH-1:0] op_b [NREQ];

    serial_add_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .IDW   (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_valid[idx]             = v;
        req_a[idx*WIDTH +: WIDTH]  = a;
        req_b[idx*WIDTH +: WIDTH]  = b;
    endtask

    task automatic pushExpected(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        e.id  = idx;
        e.sum = {1'b0, a} + {1'b0, b};
        sb.push_back(e);
    endtask

    // Called at the first sample point after the accept edge.
    task automatic waitResp(input string tag);
        int k;
        k = 1;
        while (rsp_valid !== 1'b1 && k < 64) begin
            @(negedge clk);
            #1;
            k++;
        end
        checkOutput({tag, "_latency"}, 32'(k), 32'(LAT));
    endtask

    task automatic checkResp(input string tag, input bit do_pop);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s_scoreboard: observed=response expected=no pending entry", tag);
        end else begin
            e = sb[0];
            checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
            checkOutput({tag, "_rsp_id"},    32'(rsp_id),    32'(e.id));
            checkOutput({tag, "_rsp_sum"},   32'(rsp_sum),   32'(e.sum));
            if (do_pop) e = sb.pop_front();
        end
    endtask

    task automatic issueOne(input string tag, input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        applyStimulus(idx, 1'b1, a, b);
        #1;
        checkOutput({tag, "_grant"}, 32'(req_ready), 32'(1 << idx));
        pushExpected(idx, a, b);
        @(negedge clk);
        applyStimulus(idx, 1'b0, a, b);
        #1;
        checkOutput({tag, "_busy"},  32'(busy),      32'd1);
        checkOutput({tag, "_ready"}, 32'(req_ready), 32'd0);
        waitResp(tag);
        checkResp(tag, 1'b1);
    endtask

    initial begin
        op_a[0] = 8'h12; op_b[0] = 8'h34;
        op_a[1] = 8'h7F; op_b[1] = 8'h81;
        op_a[2] = 8'hC3; op_b[2] = 8'h5A;
        op_a[3] = 8'h01; op_b[3] = 8'hFE;

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_busy",      32'(busy),      32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_id",    32'(rsp_id),    32'd0);
        checkOutput("rst_rsp_sum",   32'(rsp_sum),   32'd0);
        rst = 1'b0;

        // Single request and carry-out cases
        issueOne("single", 0, 8'h35, 8'h0A);
        issueOne("carry_ff", 2, 8'hFF, 8'hFF);
        issueOne("carry_80", 2, 8'h80, 8'h80);

        // Round-robin from a fresh pointer with all requesters held valid
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b1, op_a[i], op_b[i]);
        #1;
        for (int n = 0; n < 5; n++) begin
            checkOutput("rr_grant", 32'(req_ready), 32'(1 << (n % NREQ)));
            if (n > 0) checkOutput("rr_spacing", 32'(cyc - last_grant), 32'(WIDTH + 2));
            last_grant = cyc;
            pushExpected(n % NREQ, op_a[n % NREQ], op_b[n % NREQ]);
            @(negedge clk);
            if (n == 4) req_valid = '0;
            #1;
            checkOutput("rr_ready_add", 32'(req_ready), 32'd0);
            waitResp("rr");
            checkResp("rr", 1'b1);
            @(negedge clk);
            #1;
        end

        // Backpressure: response held, no grant until the cycle after rsp_ready
        rsp_ready = 1'b0;
        @(negedge clk);
        applyStimulus(1, 1'b1, 8'hA5, 8'h5B);
        #1;
        checkOutput("bp_grant1", 32'(req_ready), 32'b0010);
        pushExpected(1, 8'hA5, 8'h5B);
        @(negedge clk);
        applyStimulus(1, 1'b0, 8'hA5, 8'h5B);
        applyStimulus(3, 1'b1, 8'h3C, 8'h0F);
        #1;
        checkOutput("bp_ready_add", 32'(req_ready), 32'd0);
        waitResp("bp");
        for (int i = 0; i < 5; i++) begin
            checkResp("bp_hold", 1'b0);
            checkOutput("bp_hold_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("bp_no_grant_in_resp", 32'(req_ready), 32'd0);
        checkResp("bp_release", 1'b1);
        @(negedge clk);
        #1;
        checkOutput("bp_grant3", 32'(req_ready), 32'b1000);
        pushExpected(3, 8'h3C, 8'h0F);
        @(negedge clk);
        applyStimulus(3, 1'b0, 8'h3C, 8'h0F);
        #1;
        waitResp("bp3");
        checkResp("bp3", 1'b1);

        // Reset during the fourth ADD cycle aborts the operation
        @(negedge clk);
        applyStimulus(2, 1'b1, 8'h44, 8'h22);
        #1;
        checkOutput("abort_grant", 32'(req_ready), 32'b0100);
        @(negedge clk);
        applyStimulus(2, 1'b0, 8'h44, 8'h22);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_busy",      32'(busy),      32'd0);
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort_rsp_sum",   32'(rsp_sum),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 1'b1, 8'h9C, 8'h77);
        applyStimulus(3, 1'b1, 8'h10, 8'h20);
        #1;
        checkOutput("abort_rr_reset", 32'(req_ready), 32'b0010);
        pushExpected(1, 8'h9C, 8'h77);
        @(negedge clk);
        applyStimulus(1, 1'b0, 8'h9C, 8'h77);
        applyStimulus(3, 1'b0, 8'h10, 8'h20);
        #1;
        waitResp("abort_req1");
        checkResp("abort_req1", 1'b1);

        // Requester 3 withdraws before IDLE; requester 1 must win instead
        @(negedge clk);
        applyStimulus(2, 1'b1, 8'h0E, 8'hF1);
        #1;
        checkOutput("wd_grant2", 32'(req_ready), 32'b0100);
        pushExpected(2, 8'h0E, 8'hF1);
        @(negedge clk);
        applyStimulus(2, 1'b0, 8'h0E, 8'hF1);
        applyStimulus(1, 1'b1, 8'h55, 8'hAA);
        applyStimulus(3, 1'b1, 8'h66, 8'h99);
        #1;
        checkOutput("wd_ready_add", 32'(req_ready), 32'd0);
        waitResp("wd2");
        applyStimulus(3, 1'b0, 8'h66, 8'h99);
        #1;
        checkOutput("wd_ready_resp", 32'(req_ready), 32'd0);
        checkResp("wd2", 1'b1);
        @(negedge clk);
        #1;
        checkOutput("wd_grant1", 32'(req_ready), 32'b0010);
        pushExpected(1, 8'h55, 8'hAA);
        @(negedge clk);
        applyStimulus(1, 1'b0, 8'h55, 8'hAA);
        #1;
        waitResp("wd1");
        checkResp("wd1", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_add_arbiter.md
Name: serial_add_arbiter

Overview:
Shares one bit-serial adder between NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. A round-robin arbiter grants one requester at a time. The block then runs the LSB-first serial add over WIDTH cycles and returns the (WIDTH+1)-bit sum, tagged with the requester id, on a single response channel that supports backpressure. It is the scheduler in front of the serial add datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, operand width in bits (>=2)
IDW, $clog2(NREQ), width of the requester id

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester grant/accept; at most one bit set
req_a  input  NREQ*WIDTH  packed operand A; slice i belongs to requester i
req_b  input  NREQ*WIDTH  packed operand B; slice i belongs to requester i
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  IDW  index of the requester the response belongs to
rsp_sum  output  WIDTH+1  A+B; MSB is the carry-out
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset values: state=IDLE, rr_ptr=NREQ-1 (so requester 0 has top priority first), count=0, carry=0, a/b shift registers=0, sum shift register=0, rsp_id=0, rsp_valid=0, req_ready=0, busy=0.
- Reset asserted mid-operation aborts the add immediately. No response is produced. Requesters must re-present their requests.
- States: IDLE, ADD, RESP.
- IDLE:
  - req_ready = one-hot grant, combinational from req_valid. Search starts at (rr_ptr+1) mod NREQ and wraps; the first valid requester wins.
  - No valid requests: req_ready=0 and state stays IDLE.
  - On grant of requester g: latch req_a[g], req_b[g] and id=g; carry<=0; count<=0; rr_ptr<=g; go to ADD.
  - Only the granted requester sees a handshake. All others hold.
- ADD, exactly WIDTH cycles:
  - Each cycle: s = a0^b0^carry; carry <= maj(a0,b0,carry); a,b shift right by 1; s shifts into the sum register MSB-side; count++.
  - At count==WIDTH-1: go to RESP. rsp_sum = {carry_final, sum_bits}.
- RESP:
  - rsp_valid=1; rsp_id and rsp_sum held stable.
  - rsp_ready=1: go to IDLE next cycle.
  - rsp_ready=0: stay in RESP, outputs unchanged.
- req_ready=0 in ADD and RESP. A requester may deassert valid before it is granted; it is then simply not granted.
- Timing:
  - Accept at cycle t. ADD occupies t+1..t+WIDTH. rsp_valid is first high at t+WIDTH+1.
  - Latency from accept to rsp_valid is WIDTH+1 cycles.
  - Back-to-back throughput is one operation per WIDTH+2 cycles, because IDLE costs one cycle after the response handshake.
- No grant is made while in RESP, even if rsp_ready and req_valid are high in the same cycle. The next grant happens in the following IDLE cycle.
- Arithmetic is unsigned modulo 2^(WIDTH+1); the result can never overflow.
- Fairness: a continuously requesting requester is served within NREQ operations.

Decomposition:
- Package serial_add_pkg:
  - state enum {IDLE=2'd0, ADD=2'd1, RESP=2'd2}
  - default WIDTH localparam
- Sub-module serial_add_core holds the datapath only: load strobe, shift enable, a/b/sum shift registers, carry, and sum output.
- The arbiter, FSM and counter stay in serial_add_arbiter.

Test Plan:
- Single request: req0 only, a=0x35, b=0x0A. Expect req_ready[0] for 1 cycle, rsp_valid 9 cycles after accept, rsp_id=0, rsp_sum=0x03F.
- Carry-out: req2 only, a=0xFF, b=0xFF. Expect rsp_id=2, rsp_sum=0x1FE. Then a=0x80, b=0x80 gives 0x100.
- Round-robin: req0..3 all held valid with distinct operands. Grant order is 0,1,2,3,0; each response id matches its own operands. Back-to-back spacing is 10 cycles with rsp_ready=1.
- Backpressure: rsp_ready=0 for 5 cycles during RESP. Expect rsp_valid, rsp_id and rsp_sum stable; req_ready stays 0; grant occurs only on the cycle after rsp_ready is asserted.
- Reset mid-ADD: assert rst at the 4th ADD cycle. Expect immediate busy=0, rsp_valid=0 and rr_ptr reset. A subsequent request from req1 completes correctly.
- Valid withdrawn: req3 is valid during ADD and then drops before IDLE, while req1 stays valid. Expect req1 granted and no handshake to req3.
